// File: rtl/ifu_fetch.sv
// Instruction fetch stage: keeps the PC, issues one imem request at a time,
// and presents the fetched word to decode until it retires.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC    = 32'h8000_0000,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_ERR
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        err_q, err_d;
  logic        req_valid_q;
  logic        inst_valid_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_req_ready) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          inst_d  = imem_rsp_data;
          state_d = S_HOLD;
        end else if (wait_cnt_q == CNT_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          // A misaligned redirect leaves the PC on the faulting instruction.
          if (jump && (jump_addr[1:0] != 2'b00)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            pc_d    = jump ? jump_addr : pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Valid outputs are registered from the next state so no input reaches an output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      wait_cnt_q   <= '0;
      err_q        <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      wait_cnt_q   <= wait_cnt_d;
      err_q        <= err_d;
      req_valid_q  <= (state_d == S_REQ);
      inst_valid_q <= (state_d == S_HOLD);
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = pc_q;
  assign inst_valid     = inst_valid_q;
  assign inst           = inst_q;
  assign inst_pc        = pc_q;
  assign fetch_err      = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed vector table, hand sequences for reset and
// timeout, and a randomized memory/decode environment against a PC model.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, req_ready, rsp_valid, inst_ready, jump;
  logic [31:0] rsp_data, jump_addr;
  logic        req_valid, inst_valid, fetch_err;
  logic [31:0] addr, inst, inst_pc;

  logic        rst4, ready4, rsp4, iready4, jump4;
  logic [31:0] rdata4, jaddr4;
  logic        req_valid4, inst_valid4, fetch_err4;
  logic [31:0] addr4, inst4, inst_pc4;

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT_CYC(255)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_addr(addr),
    .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .jump(jump), .jump_addr(jump_addr), .fetch_err(fetch_err)
  );

  ifu_fetch #(.RESET_PC(RST_PC), .TIMEOUT_CYC(4)) u_dut4 (
    .clk(clk), .rst(rst4),
    .imem_req_valid(req_valid4), .imem_req_ready(ready4), .imem_addr(addr4),
    .imem_rsp_valid(rsp4), .imem_rsp_data(rdata4),
    .inst_valid(inst_valid4), .inst_ready(iready4), .inst(inst4), .inst_pc(inst_pc4),
    .jump(jump4), .jump_addr(jaddr4), .fetch_err(fetch_err4)
  );

  typedef struct {
    int unsigned stall;
    int unsigned dly;
    int unsigned hstall;
    logic        jmp;
    logic [31:0] jaddr;
    logic [31:0] exp_addr;
    logic        exp_err;
  } vec_t;

  vec_t tv[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    inst_ready = 1'b0; jump = 1'b0; jump_addr = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    chk("rst_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    step();
    rst = 1'b0;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cur, w, mpc;
    logic        outst, hold, hold_n, exp_req, exp_req_n, seen;
    int unsigned dly;

    rst4 = 1'b1; ready4 = 1'b1; rsp4 = 1'b0; rdata4 = '0;
    iready4 = 1'b0; jump4 = 1'b0; jaddr4 = '0;

    tv[0] = '{0, 1, 0, 1'b0, 32'h0,         32'h8000_0004, 1'b0};
    tv[1] = '{0, 1, 0, 1'b0, 32'h0,         32'h8000_0008, 1'b0};
    tv[2] = '{0, 1, 5, 1'b1, 32'h8000_0100, 32'h8000_0100, 1'b0};
    tv[3] = '{4, 7, 0, 1'b0, 32'h0,         32'h8000_0104, 1'b0};
    tv[4] = '{0, 2, 1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0};
    tv[5] = '{0, 1, 0, 1'b0, 32'h0,         32'h0000_0000, 1'b0};
    tv[6] = '{2, 3, 0, 1'b1, 32'h0000_0040, 32'h0000_0040, 1'b0};
    tv[7] = '{0, 1, 2, 1'b1, 32'h8000_0102, 32'h0000_0040, 1'b1};

    // Reset and first fetch: IDLE, REQ, WAIT, then HOLD on the third cycle.
    do_reset();
    chk("idle_req_valid", {31'b0, req_valid}, 32'd0);
    chk("idle_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("idle_inst", inst, 32'd0);
    chk("idle_err", {31'b0, fetch_err}, 32'd0);
    step();

    cur = RST_PC;
    foreach (tv[i]) begin
      w = 32'h0010_0093 + 32'(i);
      chk("req_valid", {31'b0, req_valid}, 32'd1);
      chk("req_addr", addr, cur);
      for (int unsigned s = 0; s < tv[i].stall; s++) begin
        step();
        chk("stall_req_valid", {31'b0, req_valid}, 32'd1);
        chk("stall_addr", addr, cur);
      end
      req_ready = 1'b1;
      step();
      req_ready = 1'b0;
      for (int unsigned d = 1; d < tv[i].dly; d++) begin
        chk("wait_inst_valid", {31'b0, inst_valid}, 32'd0);
        step();
      end
      chk("wait_req_valid", {31'b0, req_valid}, 32'd0);
      rsp_valid = 1'b1; rsp_data = w;
      step();
      rsp_valid = 1'b0;
      chk("hold_inst_valid", {31'b0, inst_valid}, 32'd1);
      chk("hold_inst", inst, w);
      chk("hold_inst_pc", inst_pc, cur);
      for (int unsigned h = 0; h < tv[i].hstall; h++) begin
        jump = 1'b1; jump_addr = 32'h1234_5679;
        rsp_valid = 1'b1; rsp_data = 32'hBAD0_BAD0;
        step();
        rsp_valid = 1'b0; jump = 1'b0;
        chk("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_inst", inst, w);
        chk("stall_inst_pc", inst_pc, cur);
      end
      inst_ready = 1'b1; jump = tv[i].jmp; jump_addr = tv[i].jaddr;
      step();
      inst_ready = 1'b0; jump = 1'b0;
      chk("retire_err", {31'b0, fetch_err}, {31'b0, tv[i].exp_err});
      chk("retire_req_valid", {31'b0, req_valid}, {31'b0, ~tv[i].exp_err});
      chk("retire_addr", addr, tv[i].exp_addr);
      cur = tv[i].exp_addr;
    end

    // ERR is terminal: no requests, error stays set.
    repeat (5) begin
      req_ready = 1'b1; rsp_valid = 1'b1;
      step();
    end
    clear_inputs();
    chk("err_sticky", {31'b0, fetch_err}, 32'd1);
    chk("err_req_valid", {31'b0, req_valid}, 32'd0);
    chk("err_inst_valid", {31'b0, inst_valid}, 32'd0);

    // Reset while WAITing, then a stale response: must be dropped.
    do_reset();
    step();
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstwait_req_valid", {31'b0, req_valid}, 32'd0);
    chk("rstwait_err", {31'b0, fetch_err}, 32'd0);
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    step();
    rsp_valid = 1'b0;
    chk("stale_req_valid", {31'b0, req_valid}, 32'd1);
    chk("stale_addr", addr, RST_PC);
    chk("stale_inst", inst, 32'd0);
    chk("stale_inst_valid", {31'b0, inst_valid}, 32'd0);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0; rsp_valid = 1'b1; rsp_data = 32'h0000_0013;
    step();
    rsp_valid = 1'b0;
    chk("fresh_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("fresh_inst", inst, 32'h0000_0013);

    // Randomized environment against a PC/handshake model.
    do_reset();
    step();
    mpc = RST_PC; outst = 1'b0; hold = 1'b0; exp_req = 1'b1; dly = 0;
    for (int n = 0; n < 1500; n++) begin
      chk("rnd_err", {31'b0, fetch_err}, 32'd0);
      chk("rnd_inst_valid", {31'b0, inst_valid}, {31'b0, hold});
      if (hold) begin
        chk("rnd_inst", inst, mem_word(mpc));
        chk("rnd_inst_pc", inst_pc, mpc);
      end
      if (exp_req) chk("rnd_req_due", {31'b0, req_valid}, 32'd1);
      if (outst || hold) chk("rnd_req_busy", {31'b0, req_valid}, 32'd0);
      if (req_valid) chk("rnd_addr", addr, mpc);

      req_ready = 1'($urandom_range(0, 1));
      rsp_valid = 1'b0; rsp_data = $urandom;
      inst_ready = 1'b0; jump = 1'($urandom_range(0, 1)); jump_addr = $urandom;
      hold_n = hold; exp_req_n = 1'b0;
      if (outst) begin
        if (dly == 1) begin
          rsp_valid = 1'b1; rsp_data = mem_word(mpc);
          outst = 1'b0; hold_n = 1'b1;
        end else begin
          dly--;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        rsp_valid = 1'b1;
      end
      if (req_valid && req_ready) begin
        outst = 1'b1;
        dly = $urandom_range(1, 6);
      end
      if (hold && $urandom_range(0, 2) == 0) begin
        inst_ready = 1'b1;
        jump_addr[1:0] = 2'b00;
        mpc = jump ? jump_addr : mpc + 32'd4;
        hold_n = 1'b0; exp_req_n = 1'b1;
      end
      hold = hold_n; exp_req = exp_req_n;
      step();
    end
    clear_inputs();

    // Timeout on the TIMEOUT_CYC=4 instance.
    step();
    rst4 = 1'b0;
    step();
    chk("to_req_valid", {31'b0, req_valid4}, 32'd1);
    chk("to_req_addr", addr4, RST_PC);
    step();
    repeat (3) step();
    chk("to_err_early", {31'b0, fetch_err4}, 32'd0);
    step();
    chk("to_err", {31'b0, fetch_err4}, 32'd1);
    seen = 1'b0;
    repeat (10) begin
      step();
      seen = seen | req_valid4;
    end
    chk("to_no_req", {31'b0, seen}, 32'd0);
    chk("to_err_sticky", {31'b0, fetch_err4}, 32'd1);
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    step();
    chk("to_rst_err", {31'b0, fetch_err4}, 32'd0);
    chk("to_rst_req_valid", {31'b0, req_valid4}, 32'd1);
    chk("to_rst_addr", addr4, RST_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
